// File: rtl/ffe_cma_dd_adapt.sv
// Adaptive 2-PAM feed-forward equaliser: blind CMA start, automatic hand-over to
// decision-directed LMS, with force/freeze control, restart and coefficient readback.
module ffe_cma_dd_adapt #(
  parameter int FIR_LEN    = 21,
  parameter int NB_IN      = 18,
  parameter int NBF_IN     = 15,
  parameter int NB_COEFF   = 28,
  parameter int NBF_COEFF  = 23,
  parameter int NB_OUT     = 18,
  parameter int NBF_OUT    = 15,
  parameter int NB_MU      = 16,
  parameter int MU_SHIFT   = 20,
  parameter int CMA_CYCLES = 16384,
  parameter int R2         = 32768
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_en,
  input  logic                       i_valid,
  input  logic [NB_IN-1:0]           i_sample,
  input  logic [NB_MU-1:0]           i_mu,
  input  logic [1:0]                 i_mode_force,
  input  logic                       i_restart,
  input  logic [$clog2(FIR_LEN)-1:0] i_coeff_sel,
  output logic [NB_OUT-1:0]          o_sample,
  output logic [NB_OUT-1:0]          o_decision,
  output logic                       o_valid,
  output logic [1:0]                 o_mode,
  output logic [NB_COEFF-1:0]        o_coeff
);

  localparam int C      = FIR_LEN / 2;
  localparam int SEL_W  = $clog2(FIR_LEN);
  localparam int ACC_W  = NB_IN + NB_COEFF + $clog2(FIR_LEN) + 1;
  localparam int Y_SH   = NBF_IN + NBF_COEFF - NBF_OUT;
  localparam int SQ_W   = 2 * NB_OUT;
  localparam int DIFF_W = SQ_W + 1;
  localparam int ERR_W  = NB_OUT + DIFF_W;
  localparam int ME_W   = NB_MU + 1 + NB_OUT;
  localparam int UPD_W  = ME_W + NB_IN;
  localparam int UPD_SH = NBF_OUT + NBF_IN + MU_SHIFT - NBF_COEFF;
  localparam int SUM_W  = ((UPD_W > NB_COEFF) ? UPD_W : NB_COEFF) + 1;
  localparam int CNT_W  = $clog2(CMA_CYCLES + 1);

  localparam logic [1:0] MODE_CMA = 2'd0;
  localparam logic [1:0] MODE_DD  = 2'd1;
  localparam logic [1:0] MODE_FRZ = 2'd2;

  localparam logic signed [NB_COEFF-1:0] COEFF_ONE = NB_COEFF'(1 << NBF_COEFF);
  localparam logic signed [NB_OUT-1:0]   D_POS     = NB_OUT'(1 << NBF_OUT);
  localparam logic signed [NB_OUT-1:0]   D_NEG     = NB_OUT'(-(1 << NBF_OUT));
  localparam logic signed [DIFF_W-1:0]   R2_EXT    = DIFF_W'(R2);

  localparam logic signed [ACC_W-1:0]    Y_MAX  = {{(ACC_W-NB_OUT+1){1'b0}}, {(NB_OUT-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]    Y_MIN  = {{(ACC_W-NB_OUT+1){1'b1}}, {(NB_OUT-1){1'b0}}};
  localparam logic signed [ERR_W-1:0]    E_MAX  = {{(ERR_W-NB_OUT+1){1'b0}}, {(NB_OUT-1){1'b1}}};
  localparam logic signed [ERR_W-1:0]    E_MIN  = {{(ERR_W-NB_OUT+1){1'b1}}, {(NB_OUT-1){1'b0}}};
  localparam logic signed [SUM_W-1:0]    C_MAX  = {{(SUM_W-NB_COEFF+1){1'b0}}, {(NB_COEFF-1){1'b1}}};
  localparam logic signed [SUM_W-1:0]    C_MIN  = {{(SUM_W-NB_COEFF+1){1'b1}}, {(NB_COEFF-1){1'b0}}};
  localparam logic signed [NB_OUT-1:0]   YO_MAX = {1'b0, {(NB_OUT-1){1'b1}}};
  localparam logic signed [NB_OUT-1:0]   YO_MIN = {1'b1, {(NB_OUT-1){1'b0}}};
  localparam logic signed [NB_COEFF-1:0] CO_MAX = {1'b0, {(NB_COEFF-1){1'b1}}};
  localparam logic signed [NB_COEFF-1:0] CO_MIN = {1'b1, {(NB_COEFF-1){1'b0}}};

  logic signed [NB_IN-1:0]    dl        [FIR_LEN];
  logic signed [NB_IN-1:0]    taps      [FIR_LEN];
  logic signed [NB_COEFF-1:0] coeff     [FIR_LEN];
  logic signed [NB_COEFF-1:0] coeff_nxt [FIR_LEN];
  logic signed [UPD_W-1:0]    upd       [FIR_LEN];
  logic signed [SUM_W-1:0]    csum      [FIR_LEN];

  logic signed [NB_OUT-1:0] y, dec_now, err, y_nxt;
  logic signed [SQ_W-1:0]   sq, sq_fl;
  logic signed [DIFF_W-1:0] diff;
  logic signed [ERR_W-1:0]  cma_p, e_pre;
  logic signed [ME_W-1:0]   me;
  logic signed [ACC_W-1:0]  acc, acc_sh;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [1:0]               mode_nxt;
  logic [NB_COEFF-1:0]      sel_val;

  always_comb begin
    taps[0] = i_sample;
    for (int k = 1; k < FIR_LEN; k++) taps[k] = dl[k-1];
  end

  // Error from the registered y[n]; the delay line still holds its regressor.
  always_comb begin
    y       = o_sample;
    dec_now = y[NB_OUT-1] ? D_NEG : D_POS;
    sq      = SQ_W'(y) * SQ_W'(y);
    sq_fl   = sq >>> NBF_OUT;
    diff    = DIFF_W'(sq_fl) - R2_EXT;
    cma_p   = ERR_W'(y) * ERR_W'(diff);
    e_pre   = (o_mode == MODE_DD) ? (ERR_W'(y) - ERR_W'(dec_now)) : (cma_p >>> NBF_OUT);
    if (e_pre > E_MAX)      err = YO_MAX;
    else if (e_pre < E_MIN) err = YO_MIN;
    else                    err = e_pre[NB_OUT-1:0];
    me = ME_W'($signed({1'b0, i_mu})) * ME_W'(err);
  end

  // Updated taps are also what the incoming sample is filtered with.
  always_comb begin
    for (int k = 0; k < FIR_LEN; k++) begin
      upd[k]  = (UPD_W'(me) * UPD_W'(dl[k])) >>> UPD_SH;
      csum[k] = SUM_W'(coeff[k]) - SUM_W'(upd[k]);
      if (o_mode == MODE_FRZ)   coeff_nxt[k] = coeff[k];
      else if (csum[k] > C_MAX) coeff_nxt[k] = CO_MAX;
      else if (csum[k] < C_MIN) coeff_nxt[k] = CO_MIN;
      else                      coeff_nxt[k] = csum[k][NB_COEFF-1:0];
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < FIR_LEN; k++) acc = acc + ACC_W'(coeff_nxt[k]) * ACC_W'(taps[k]);
    acc_sh = acc >>> Y_SH;
    if (acc_sh > Y_MAX)      y_nxt = YO_MAX;
    else if (acc_sh < Y_MIN) y_nxt = YO_MIN;
    else                     y_nxt = acc_sh[NB_OUT-1:0];
  end

  always_comb begin
    cnt_nxt  = cnt;
    mode_nxt = o_mode;
    case (i_mode_force)
      2'b01:   mode_nxt = MODE_CMA;
      2'b10:   mode_nxt = MODE_DD;
      2'b11:   mode_nxt = MODE_FRZ;
      default: begin
        if (cnt < CNT_W'(CMA_CYCLES)) cnt_nxt = cnt + CNT_W'(1);
        mode_nxt = (cnt_nxt < CNT_W'(CMA_CYCLES)) ? MODE_CMA : MODE_DD;
      end
    endcase
  end

  assign sel_val = (i_coeff_sel < SEL_W'(FIR_LEN)) ? coeff[i_coeff_sel] : '0;

  always_ff @(posedge clk) begin
    if (!rst)      o_coeff <= '0;
    else if (i_en) o_coeff <= sel_val;
  end

  // Restart shares the reset path and wins over a coincident sample.
  always_ff @(posedge clk) begin
    if (!rst || (i_en && i_restart)) begin
      for (int k = 0; k < FIR_LEN; k++) begin
        dl[k]    <= '0;
        coeff[k] <= (k == C) ? COEFF_ONE : '0;
      end
      o_sample   <= '0;
      o_decision <= '0;
      o_valid    <= 1'b0;
      o_mode     <= MODE_CMA;
      cnt        <= '0;
    end else if (i_en) begin
      o_valid <= i_valid;
      if (o_valid) o_decision <= dec_now;
      if (i_valid) begin
        for (int k = 0; k < FIR_LEN; k++) begin
          dl[k]    <= taps[k];
          coeff[k] <= coeff_nxt[k];
        end
        o_sample <= y_nxt;
        cnt      <= cnt_nxt;
        o_mode   <= mode_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ffe_cma_dd_adapt.sv
// Directed bench for ffe_cma_dd_adapt: reset, freeze/CMA/DD impulse responses,
// auto mode hand-over with gaps and stalls, and restart.
module tb_ffe_cma_dd_adapt;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en, i_valid, i_restart;
  logic [17:0] i_sample;
  logic [15:0] i_mu;
  logic [1:0]  i_mode_force;
  logic [4:0]  i_coeff_sel;
  logic [17:0] o_sample, o_decision;
  logic        o_valid;
  logic [1:0]  o_mode;
  logic [27:0] o_coeff;

  int total = 0;
  int bad   = 0;

  ffe_cma_dd_adapt #(.CMA_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_valid(i_valid), .i_sample(i_sample),
    .i_mu(i_mu), .i_mode_force(i_mode_force), .i_restart(i_restart),
    .i_coeff_sel(i_coeff_sel), .o_sample(o_sample), .o_decision(o_decision),
    .o_valid(o_valid), .o_mode(o_mode), .o_coeff(o_coeff)
  );

  always #5 clk = ~clk;

  // One clock with the given inputs; outputs are looked at 1 ns after the edge.
  task automatic drive(input logic en, input logic valid, input logic [17:0] s);
    i_en = en; i_valid = valid; i_sample = s;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; i_en = 1'b1; i_valid = 1'b0; i_restart = 1'b0; i_sample = '0;
    i_mu = 16'd32; i_mode_force = 2'b00; i_coeff_sel = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_en = 1'b1; i_valid = 1'b1; i_restart = 1'b0; i_sample = 18'd16384;
    i_mu = 16'd32; i_mode_force = 2'b10; i_coeff_sel = 5'd10;
    repeat (2) @(posedge clk);
    #1;
    total++; if (o_coeff !== 28'd0) begin bad++; $display("[TB] FAIL reset_coeff got=%0d exp=0", o_coeff); end
    total++; if (o_sample !== 18'd0) begin bad++; $display("[TB] FAIL reset_sample got=%0d exp=0", o_sample); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0b exp=0", o_valid); end
    total++; if (o_mode !== 2'd0) begin bad++; $display("[TB] FAIL reset_mode got=%0d exp=0", o_mode); end
    total++; if (o_decision !== 18'd0) begin bad++; $display("[TB] FAIL reset_decision got=%0d exp=0", o_decision); end
    rst = 1'b1; i_mode_force = 2'b00;
    for (int k = 0; k < 21; k++) begin
      i_coeff_sel = 5'(k);
      drive(1'b1, 1'b0, 18'd0);
      total++;
      if (o_coeff !== ((k == 10) ? 28'd8388608 : 28'd0)) begin
        bad++; $display("[TB] FAIL reset_sweep k=%0d got=%0d", k, o_coeff);
      end
    end
    i_coeff_sel = 5'd25;
    drive(1'b1, 1'b0, 18'd0);
    total++; if (o_coeff !== 28'd0) begin bad++; $display("[TB] FAIL sel_out_of_range got=%0d exp=0", o_coeff); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("[TB] FAIL idle_valid got=%0b exp=0", o_valid); end
  endtask

  task automatic test_freeze();
    do_reset();
    i_mode_force = 2'b11;
    for (int n = 0; n < 16; n++) begin
      drive(1'b1, 1'b1, (n == 0) ? 18'd16384 : 18'd0);
      total++;
      if (o_sample !== ((n == 10) ? 18'd16384 : 18'd0)) begin
        bad++; $display("[TB] FAIL freeze_y n=%0d got=%0d", n, $signed(o_sample));
      end
      total++; if (o_valid !== 1'b1) begin bad++; $display("[TB] FAIL freeze_valid n=%0d got=%0b exp=1", n, o_valid); end
      total++; if (o_mode !== 2'd2) begin bad++; $display("[TB] FAIL freeze_mode n=%0d got=%0d exp=2", n, o_mode); end
      if (n >= 1) begin
        total++;
        if (o_decision !== 18'd32768) begin
          bad++; $display("[TB] FAIL freeze_decision n=%0d got=%0d exp=32768", n, $signed(o_decision));
        end
      end
    end
    for (int k = 0; k < 21; k++) begin
      i_coeff_sel = 5'(k);
      drive(1'b1, 1'b0, 18'd0);
      total++;
      if (o_coeff !== ((k == 10) ? 28'd8388608 : 28'd0)) begin
        bad++; $display("[TB] FAIL freeze_coeff k=%0d got=%0d", k, o_coeff);
      end
    end
  endtask

  task automatic test_cma_step();
    do_reset();
    i_mode_force = 2'b01; i_mu = 16'd32;
    for (int n = 0; n < 23; n++) begin
      drive(1'b1, 1'b1, (n == 0) ? 18'd16384 : 18'd0);
      total++;
      if (o_sample !== ((n == 10) ? 18'd16384 : 18'd0)) begin
        bad++; $display("[TB] FAIL cma_y n=%0d got=%0d", n, $signed(o_sample));
      end
    end
    total++; if (o_mode !== 2'd0) begin bad++; $display("[TB] FAIL cma_mode got=%0d exp=0", o_mode); end
    for (int k = 0; k < 21; k++) begin
      i_coeff_sel = 5'(k);
      drive(1'b1, 1'b0, 18'd0);
      total++;
      if (o_coeff !== ((k == 10) ? 28'd8388656 : 28'd0)) begin
        bad++; $display("[TB] FAIL cma_coeff k=%0d got=%0d", k, o_coeff);
      end
    end
  endtask

  task automatic test_dd_step();
    do_reset();
    i_mode_force = 2'b10; i_mu = 16'd32;
    for (int n = 0; n < 23; n++) begin
      drive(1'b1, 1'b1, (n == 0) ? 18'd16384 : 18'd0);
      total++;
      if (o_sample !== ((n == 10) ? 18'd16384 : 18'd0)) begin
        bad++; $display("[TB] FAIL dd_y n=%0d got=%0d", n, $signed(o_sample));
      end
    end
    total++; if (o_mode !== 2'd1) begin bad++; $display("[TB] FAIL dd_mode got=%0d exp=1", o_mode); end
    for (int k = 0; k < 21; k++) begin
      i_coeff_sel = 5'(k);
      drive(1'b1, 1'b0, 18'd0);
      total++;
      if (o_coeff !== ((k == 10) ? 28'd8388672 : 28'd128)) begin
        bad++; $display("[TB] FAIL dd_coeff k=%0d got=%0d", k, o_coeff);
      end
    end
  endtask

  task automatic test_auto_switch();
    logic [15:0] en_pat, val_pat;
    logic        exp_valid;
    int          accepted;
    do_reset();
    i_mode_force = 2'b00;
    en_pat  = 16'b1111_1110_1111_0011;
    val_pat = 16'b1111_0111_1011_1101;
    exp_valid = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 16; i++) begin
      drive(en_pat[i], val_pat[i], 18'd0);
      if (en_pat[i]) exp_valid = val_pat[i];
      if (en_pat[i] && val_pat[i]) accepted++;
      total++;
      if (o_mode !== ((accepted >= 8) ? 2'd1 : 2'd0)) begin
        bad++; $display("[TB] FAIL auto_mode i=%0d accepted=%0d got=%0d", i, accepted, o_mode);
      end
      total++;
      if (o_valid !== exp_valid) begin
        bad++; $display("[TB] FAIL auto_valid i=%0d got=%0b exp=%0b", i, o_valid, exp_valid);
      end
    end
  endtask

  task automatic test_restart();
    do_reset();
    i_mode_force = 2'b00;
    repeat (5) drive(1'b1, 1'b1, 18'd0);
    total++; if (o_mode !== 2'd0) begin bad++; $display("[TB] FAIL pre_restart_auto got=%0d exp=0", o_mode); end
    i_mode_force = 2'b10;
    for (int n = 0; n < 23; n++) drive(1'b1, 1'b1, (n == 0) ? 18'd16384 : 18'd0);
    total++; if (o_mode !== 2'd1) begin bad++; $display("[TB] FAIL pre_restart_mode got=%0d exp=1", o_mode); end
    i_coeff_sel = 5'd0;
    drive(1'b1, 1'b0, 18'd0);
    total++; if (o_coeff !== 28'd128) begin bad++; $display("[TB] FAIL pre_restart_coeff got=%0d exp=128", o_coeff); end
    i_restart = 1'b1;
    drive(1'b1, 1'b1, 18'd16384);
    i_restart = 1'b0;
    total++; if (o_valid !== 1'b0) begin bad++; $display("[TB] FAIL restart_valid got=%0b exp=0", o_valid); end
    total++; if (o_mode !== 2'd0) begin bad++; $display("[TB] FAIL restart_mode got=%0d exp=0", o_mode); end
    total++; if (o_sample !== 18'd0) begin bad++; $display("[TB] FAIL restart_sample got=%0d exp=0", o_sample); end
    for (int k = 0; k < 21; k++) begin
      i_coeff_sel = 5'(k);
      drive(1'b1, 1'b0, 18'd0);
      total++;
      if (o_coeff !== ((k == 10) ? 28'd8388608 : 28'd0)) begin
        bad++; $display("[TB] FAIL restart_coeff k=%0d got=%0d", k, o_coeff);
      end
    end
    i_mode_force = 2'b00;
    for (int j = 1; j <= 12; j++) begin
      drive(1'b1, 1'b1, 18'd0);
      total++;
      if (o_mode !== ((j >= 8) ? 2'd1 : 2'd0)) begin
        bad++; $display("[TB] FAIL restart_count j=%0d got=%0d", j, o_mode);
      end
      total++;
      if (o_sample !== 18'd0) begin
        bad++; $display("[TB] FAIL restart_dropped j=%0d got=%0d exp=0", j, $signed(o_sample));
      end
    end
  endtask

  initial begin
    test_reset();
    test_freeze();
    test_cma_step();
    test_dd_step();
    test_auto_switch();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ffe_cma_dd_adapt.md
Name: ffe_cma_dd_adapt

Overview:
Adaptive feed-forward equaliser for real-valued 2-PAM symbols. It is the parametrised successor of the CMA-only FIR top. The block starts blind in CMA mode, then switches automatically to decision-directed (DD) LMS after a programmable number of samples, and can be forced to CMA, DD or freeze. It sits between the channel sample source and the symbol sink, and exposes coefficient readback and a restart control for bench and debug use.

Parameters:
FIR_LEN, 21, number of taps (odd); the centre tap index is C = FIR_LEN/2.
NB_IN, 18, input width. NBF_IN, 15, input fractional bits.
NB_COEFF, 28, coefficient width. NBF_COEFF, 23, coefficient fractional bits.
NB_OUT, 18, output, decision and error width. NBF_OUT, 15, their fractional bits.
NB_MU, 16, step-size width (unsigned integer).
MU_SHIFT, 20, effective step is mu/2^MU_SHIFT.
CMA_CYCLES, 16384, number of accepted samples spent in auto-CMA before switching to DD.
R2, 32768, CMA radius in Q(NB_OUT,NBF_OUT); the default is 1.0.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-low
i_en  in  1  global enable; when low, all state holds
i_valid  in  1  i_sample is valid this cycle
i_sample  in  NB_IN  signed input sample x[n]
i_mu  in  NB_MU  step size
i_mode_force  in  2  00 auto, 01 force CMA, 10 force DD, 11 freeze
i_restart  in  1  one-cycle pulse; reinitialise the adaptive state
i_coeff_sel  in  clog2(FIR_LEN)  coefficient readback index
o_sample  out  NB_OUT  equaliser output y[n]
o_decision  out  NB_OUT  slicer output d[n], +/-1.0
o_valid  out  1  o_sample valid
o_mode  out  2  current state: 0 CMA, 1 DD, 2 FREEZE
o_coeff  out  NB_COEFF  registered copy of coeff[i_coeff_sel]

Behaviour:
- An "accepted" sample is a cycle with rst=1, i_en=1 and i_valid=1. Only accepted samples shift the delay line, advance the counters or update coefficients.
- Reset (rst=0):
  - coeff[C] = 2^NBF_COEFF (1.0); all other coefficients = 0.
  - Delay line and pipeline registers = 0.
  - o_sample = 0, o_decision = 0, o_valid = 0, o_coeff = 0.
  - o_mode = CMA; sample counter = 0.
- i_restart=1 (with i_en=1): same effect as reset, except o_coeff keeps tracking i_coeff_sel. Restart has priority over a simultaneous accepted sample; that sample is dropped.
- Latency: x[n] accepted in cycle n. y[n] appears on o_sample with o_valid=1 in cycle n+1. d[n] appears in cycle n+2.
- o_valid is the one-cycle-delayed accept.
- i_en=0 holds all outputs and state; o_valid also holds.
- FIR output:
  - y = sum of coeff[k]*x[n-k], computed at full precision.
  - Arithmetic shift right by NBF_IN+NBF_COEFF-NBF_OUT (floor), then saturate to NB_OUT bits.
- Slicer: d = +2^NBF_OUT if y >= 0, else -2^NBF_OUT. Zero therefore maps to +1.0.
- Error e[n] (computed in cycle n+1 from registered y[n]), each intermediate floored to NBF_OUT and the result saturated to NB_OUT:
  - CMA: e = y*((y*y) - R2).
  - DD: e = y - d.
  - FREEZE: no error is used.
- Coefficient update:
  - For every k: coeff[k] <= sat_NB_COEFF(coeff[k] - ((mu*e*xr[k]) >>> (NBF_OUT+NBF_IN+MU_SHIFT-NBF_COEFF))).
  - xr is the regressor snapshot aligned with y[n].
  - The update is written on the edge that ends cycle n+1 and is used by y[n+1] onward. It is applied only on an accepted cycle and never in FREEZE.
- Mode FSM:
  - i_mode_force is sampled on accepted cycles only.
  - 01 forces CMA, 10 forces DD, 11 forces FREEZE.
  - 00 (auto): state is CMA while counter < CMA_CYCLES, otherwise DD.
  - The counter increments on each accepted sample while in auto-CMA only, and saturates at CMA_CYCLES.
  - Forced modes do not change the counter.
- o_coeff is registered: coeff[i_coeff_sel] one cycle later. An out-of-range select returns 0.

Test Plan:
1. Reset: hold rst=0 for 2 cycles, then sweep i_coeff_sel over 0..20 → o_coeff = 8388608 at 10 and 0 elsewhere; o_sample = 0, o_valid = 0, o_mode = 0.
2. Freeze impulse: force 11; x = 16384 at n=0, zeros after → o_sample = 16384 at cycle 11 and 0 otherwise; o_decision = +32768; coefficients unchanged.
3. CMA step: force 01, mu = 32, same impulse → after the impulse passes the centre tap, coeff[10] = 8388608+48 (e = -12288); all other taps stay 0.
4. DD step: force 10, mu = 32, same impulse → coeff[10] = 8388672 (e = -16384); every other tap = 128 (y = 0 gives e = -32768).
5. Auto switch with CMA_CYCLES = 8: send 8 accepted samples with i_valid gaps and an i_en=0 stall inserted → o_mode goes 0→1 only after the 8th accepted sample; gaps do not count.
6. Restart: pulse i_restart mid-stream, coincident with a valid sample → coefficients return to reset values, o_mode = 0, counter = 0, the sample is dropped, o_valid = 0 next cycle.
